wb_ctrl_pipe: RTL and testbench

Parametrised successor to the single-cycle writeback-control decoder. It decodes opcode/rd into a writeback control word {reg addr, data select, write enable} and carries that word through a DEPTH-stage registered pipeline with valid, stall and flush control. It also provides register-hazard lookup against all in-flight writes and a retired-instruction counter. It sits between decode and the register-file write port.

---
 rtl/wb_ctrl_pipe.sv | 143 ++++++++++++++
 tb/tb_wb_ctrl_pipe.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_ctrl_pipe.sv
// Writeback-control pipeline: decodes opcode/rd into {addr, sel, en}, then carries it through
// DEPTH registered stages with stall/flush, hazard lookup and a retired-entry counter.
module wb_ctrl_pipe #(
  parameter int REG_AW      = 5,
  parameter int DEPTH       = 3,
  parameter int X0_SUPPRESS = 1,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [REG_AW-1:0] rd,
  input  logic              stall,
  input  logic              flush,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  output logic              wb_valid,
  output logic [REG_AW+2:0] wb_op,
  output logic              wb_we,
  output logic              hazard1,
  output logic              hazard2,
  output logic              load_use1,
  output logic              load_use2,
  output logic [CNT_W-1:0]  retire_cnt
);

  if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
    $error("wb_ctrl_pipe: DEPTH must be in 1..4");
  end

  function automatic logic [1:0] dec_sel(input logic [6:0] op);
    logic [1:0] s;
    case (op)
      7'b0000011: s = 2'b01;
      7'b1100111: s = 2'b11;
      7'b1101111: s = 2'b11;
      7'b0110111: s = 2'b10;
      7'b0010111: s = 2'b10;
      default:    s = 2'b00;
    endcase
    return s;
  endfunction

  function automatic logic dec_en(input logic [6:0] op, input logic [REG_AW-1:0] r);
    logic e;
    case (op)
      7'b1110011: e = 1'b0;
      7'b0100011: e = 1'b0;
      7'b1100011: e = 1'b0;
      default:    e = 1'b1;
    endcase
    if ((X0_SUPPRESS != 0) && (r == {REG_AW{1'b0}})) begin
      e = 1'b0;
    end else begin
      e = e;
    end
    return e;
  endfunction

  logic [DEPTH-1:0]  v_r;
  logic [REG_AW-1:0] addr_r [DEPTH];
  logic [1:0]        sel_r  [DEPTH];
  logic              en_r   [DEPTH];
  logic [CNT_W-1:0]  cnt_r;
  logic [1:0]        in_sel_s;
  logic              in_en_s;
  logic              accept_s;

  assign in_sel_s = dec_sel(opcode);
  assign in_en_s  = dec_en(opcode, rd);
  assign accept_s = in_valid & ~stall & ~flush;

  // Stage registers: flush clears every valid bit, stall freezes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_r <= {DEPTH{1'b0}};
      for (int k = 0; k < DEPTH; k++) begin
        addr_r[k] <= {REG_AW{1'b0}};
        sel_r[k]  <= 2'b00;
        en_r[k]   <= 1'b0;
      end
    end else if (flush) begin
      v_r <= {DEPTH{1'b0}};
    end else if (!stall) begin
      v_r[0]    <= accept_s;
      addr_r[0] <= rd;
      sel_r[0]  <= in_sel_s;
      en_r[0]   <= in_en_s;
      for (int k = 1; k < DEPTH; k++) begin
        v_r[k]    <= v_r[k-1];
        addr_r[k] <= addr_r[k-1];
        sel_r[k]  <= sel_r[k-1];
        en_r[k]   <= en_r[k-1];
      end
    end else begin
      v_r <= v_r;
    end
  end

  // Retire counter: the final-stage entry commits on any non-stalled edge, even during flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (v_r[DEPTH-1] && !stall) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign in_ready   = ~stall;
  assign wb_valid   = v_r[DEPTH-1];
  assign wb_op      = {addr_r[DEPTH-1], sel_r[DEPTH-1], en_r[DEPTH-1]};
  assign wb_we      = v_r[DEPTH-1] & en_r[DEPTH-1] & ~stall;
  assign retire_cnt = cnt_r;

  // Hazard lookup; scanning oldest to youngest lets the lowest-index match decide load_use.
  always_comb begin
    hazard1   = 1'b0;
    hazard2   = 1'b0;
    load_use1 = 1'b0;
    load_use2 = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (v_r[k] && en_r[k] && (addr_r[k] == rs1) &&
          !((X0_SUPPRESS != 0) && (rs1 == {REG_AW{1'b0}}))) begin
        hazard1   = 1'b1;
        load_use1 = (sel_r[k] == 2'b01);
      end else begin
        hazard1   = hazard1;
      end
      if (v_r[k] && en_r[k] && (addr_r[k] == rs2) &&
          !((X0_SUPPRESS != 0) && (rs2 == {REG_AW{1'b0}}))) begin
        hazard2   = 1'b1;
        load_use2 = (sel_r[k] == 2'b01);
      end else begin
        hazard2   = hazard2;
      end
    end
  end

endmodule

// File: tb/tb_wb_ctrl_pipe.sv
// Directed bench for wb_ctrl_pipe: decode table plus stall, flush, hazard, wrap and reset sequences.
module tb_wb_ctrl_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, stall, flush;
  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;
  logic       in_ready, wb_valid, wb_we, hazard1, hazard2, load_use1, load_use2;
  logic [7:0] wb_op;
  logic [31:0] retire_cnt;
  logic       in_ready_4, wb_valid_4, wb_we_4, hz1_4, hz2_4, lu1_4, lu2_4;
  logic [7:0] wb_op_4;
  logic [3:0] retire_cnt_4;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_cnt;

  always #5 clk = ~clk;

  wb_ctrl_pipe #(.REG_AW(5), .DEPTH(3), .X0_SUPPRESS(1), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .stall(stall), .flush(flush), .rs1(rs1), .rs2(rs2),
    .wb_valid(wb_valid), .wb_op(wb_op), .wb_we(wb_we), .hazard1(hazard1),
    .hazard2(hazard2), .load_use1(load_use1), .load_use2(load_use2),
    .retire_cnt(retire_cnt));

  wb_ctrl_pipe #(.REG_AW(5), .DEPTH(3), .X0_SUPPRESS(1), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_4),
    .opcode(opcode), .rd(rd), .stall(stall), .flush(flush), .rs1(rs1), .rs2(rs2),
    .wb_valid(wb_valid_4), .wb_op(wb_op_4), .wb_we(wb_we_4), .hazard1(hz1_4),
    .hazard2(hz2_4), .load_use1(lu1_4), .load_use2(lu2_4),
    .retire_cnt(retire_cnt_4));

  typedef struct {
    logic [6:0] op;
    logic [4:0] r;
    logic [7:0] exp_op;
    logic       exp_we;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    exp_cnt = 32'd0;
    tick;
  endtask

  initial begin
    vecs[0] = '{7'b0000011, 5'd5,  {5'd5,  2'b01, 1'b1}, 1'b1};
    vecs[1] = '{7'b1101111, 5'd1,  {5'd1,  2'b11, 1'b1}, 1'b1};
    vecs[2] = '{7'b0110111, 5'd7,  {5'd7,  2'b10, 1'b1}, 1'b1};
    vecs[3] = '{7'b0100011, 5'd3,  {5'd3,  2'b00, 1'b0}, 1'b0};
    vecs[4] = '{7'b0010011, 5'd0,  {5'd0,  2'b00, 1'b0}, 1'b0};
    vecs[5] = '{7'b1100111, 5'd31, {5'd31, 2'b11, 1'b1}, 1'b1};
    vecs[6] = '{7'b0010111, 5'd12, {5'd12, 2'b10, 1'b1}, 1'b1};
    vecs[7] = '{7'b1100011, 5'd4,  {5'd4,  2'b00, 1'b0}, 1'b0};
    vecs[8] = '{7'b1110011, 5'd2,  {5'd2,  2'b00, 1'b0}, 1'b0};
    vecs[9] = '{7'b0110011, 5'd9,  {5'd9,  2'b00, 1'b1}, 1'b1};

    in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    opcode = 7'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    rst_n = 1'b0;
    #12;
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_op",    {24'd0, wb_op}, 32'd0);
    chk("rst_wb_we",    {31'd0, wb_we}, 32'd0);
    chk("rst_hazards",  {28'd0, hazard1, hazard2, load_use1, load_use2}, 32'd0);
    chk("rst_cnt",      retire_cnt, 32'd0);
    chk("in_ready",     {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    exp_cnt = 32'd0;
    tick;

    // Decode table, one entry at a time through the 3-stage pipe.
    for (int i = 0; i < 10; i++) begin
      opcode = vecs[i].op; rd = vecs[i].r; in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      tick;
      chk($sformatf("v%0d_early", i), {31'd0, wb_valid}, 32'd0);
      tick;
      chk($sformatf("v%0d_wb_valid", i), {31'd0, wb_valid}, 32'd1);
      chk($sformatf("v%0d_wb_op", i), {24'd0, wb_op}, {24'd0, vecs[i].exp_op});
      chk($sformatf("v%0d_wb_we", i), {31'd0, wb_we}, {31'd0, vecs[i].exp_we});
      tick;
      exp_cnt++;
      chk($sformatf("v%0d_cnt", i), retire_cnt, exp_cnt);
      chk($sformatf("v%0d_drain", i), {31'd0, wb_valid}, 32'd0);
    end

    // Stall while in stage 1, then stall again at writeback.
    opcode = 7'b0000011; rd = 5'd6; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    stall = 1'b1;
    #1;
    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    tick;
    tick;
    chk("stall_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("stall_wb_we", {31'd0, wb_we}, 32'd0);
    stall = 1'b0;
    tick;
    chk("stall_late_valid", {31'd0, wb_valid}, 32'd1);
    chk("stall_late_op", {24'd0, wb_op}, {24'd0, 5'd6, 2'b01, 1'b1});
    stall = 1'b1;
    #1;
    chk("stall_wb_we_hold", {31'd0, wb_we}, 32'd0);
    tick;
    chk("stall_hold_valid", {31'd0, wb_valid}, 32'd1);
    chk("stall_hold_op", {24'd0, wb_op}, {24'd0, 5'd6, 2'b01, 1'b1});
    chk("stall_hold_cnt", retire_cnt, exp_cnt);
    stall = 1'b0;
    #1;
    chk("stall_release_we", {31'd0, wb_we}, 32'd1);
    tick;
    exp_cnt++;
    chk("stall_commit_cnt", retire_cnt, exp_cnt);
    tick;
    chk("stall_no_dup", retire_cnt, exp_cnt);

    // Flush with stall: three entries in flight, writeback entry must not commit.
    in_valid = 1'b1;
    opcode = 7'b0110111; rd = 5'd10; tick;
    opcode = 7'b0110011; rd = 5'd11; tick;
    opcode = 7'b0000011; rd = 5'd12; tick;
    rs1 = 5'd12; rs2 = 5'd11;
    #1;
    chk("pre_flush_hz1", {31'd0, hazard1}, 32'd1);
    chk("pre_flush_lu1", {31'd0, load_use1}, 32'd1);
    chk("pre_flush_hz2", {31'd0, hazard2}, 32'd1);
    flush = 1'b1; stall = 1'b1;
    #1;
    chk("flush_we", {31'd0, wb_we}, 32'd0);
    tick;
    flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("flush_hazards", {28'd0, hazard1, hazard2, load_use1, load_use2}, 32'd0);
    chk("flush_cnt", retire_cnt, exp_cnt);
    tick; tick; tick;
    chk("flush_no_ghost", {31'd0, wb_valid}, 32'd0);
    chk("flush_cnt_after", retire_cnt, exp_cnt);

    // Hazard: ALU rd9 in stage 2, bubble, load rd9 in stage 0.
    in_valid = 1'b1; opcode = 7'b0110011; rd = 5'd9; tick;
    in_valid = 1'b0; tick;
    in_valid = 1'b1; opcode = 7'b0000011; rd = 5'd9; tick;
    in_valid = 1'b0;
    rs1 = 5'd9; rs2 = 5'd0;
    #1;
    chk("hz_s0s2_hz1", {31'd0, hazard1}, 32'd1);
    chk("hz_s0s2_lu1", {31'd0, load_use1}, 32'd1);
    chk("hz_rs2_x0", {30'd0, hazard2, load_use2}, 32'd0);
    tick;
    exp_cnt++;
    chk("hz_alu_commit", retire_cnt, exp_cnt);
    tick; tick;
    exp_cnt++;
    // Load then ALU to rd9: youngest match is the ALU write.
    in_valid = 1'b1; opcode = 7'b0000011; rd = 5'd9; tick;
    opcode = 7'b0110011; rd = 5'd9; tick;
    opcode = 7'b0100011; rd = 5'd8; tick;
    in_valid = 1'b0;
    rs2 = 5'd8;
    #1;
    chk("hz_young_alu_hz1", {31'd0, hazard1}, 32'd1);
    chk("hz_young_alu_lu1", {31'd0, load_use1}, 32'd0);
    chk("hz_store_no_hz2", {31'd0, hazard2}, 32'd0);
    tick; tick; tick; tick;
    exp_cnt = exp_cnt + 32'd3;
    chk("hz_cnt", retire_cnt, exp_cnt);
    rs1 = 5'd0; rs2 = 5'd0;

    // Counter wrap: 17 commits, 4-bit counter ends at 1.
    do_reset;
    opcode = 7'b0010011; rd = 5'd1; in_valid = 1'b1;
    for (int i = 0; i < 17; i++) tick;
    in_valid = 1'b0;
    tick; tick; tick;
    chk("wrap_cnt32", retire_cnt, 32'd17);
    chk("wrap_cnt4", {28'd0, retire_cnt_4}, 32'd1);

    // Async reset mid-stream.
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) tick;
    rs1 = 5'd1;
    #1;
    chk("pre_rst_valid", {31'd0, wb_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, wb_valid}, 32'd0);
    chk("async_rst_cnt", retire_cnt, 32'd0);
    chk("async_rst_cnt4", {28'd0, retire_cnt_4}, 32'd0);
    chk("async_rst_hz", {31'd0, hazard1}, 32'd0);
    in_valid = 1'b0;
    #10;
    rst_n = 1'b1;
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
